// File: rtl/la_bec_pkg.sv
// Shared types and constants for the LA-to-BEC loader bridge.
package la_bec_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_BUSY,
    S_DONE
  } state_t;

  localparam logic [15:0] STATUS_IDLE = 16'hAB30;
  localparam logic [15:0] STATUS_LOAD = 16'hAB41;
  localparam logic [15:0] STATUS_BUSY = 16'hAB42;
  localparam logic [15:0] STATUS_ERR  = 16'hAB44;
  localparam logic [15:0] STATUS_DONE = 16'hAB51;

  localparam int CTRL_WR     = 0;
  localparam int CTRL_GO     = 1;
  localparam int CTRL_RD     = 2;
  localparam int CTRL_CLR    = 3;
  localparam int CTRL_SEL_LO = 4;
  localparam int CTRL_IDX_LO = 8;

  // Number of 32-bit LA words needed to carry one field element.
  function automatic int nwords(input int width);
    return (width + 31) / 32;
  endfunction

  // The sticky error code masks whatever state the FSM is in.
  function automatic logic [15:0] status_code(input state_t s, input logic err);
    if (err) return STATUS_ERR;
    case (s)
      S_IDLE:  return STATUS_IDLE;
      S_LOAD:  return STATUS_LOAD;
      S_BUSY:  return STATUS_BUSY;
      S_DONE:  return STATUS_DONE;
      default: return STATUS_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/la_toggle_detect.sv
// Toggle-coded command detector: remembers last cycle's value and flags any bit that changed.
module la_toggle_detect #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] din,
  output logic [N-1:0] events
);

  logic [N-1:0] hist;

  // History follows the registered input every cycle, including during reset, so it is seeded and no event appears on release.
  always_ff @(posedge clk) begin
    hist <= din;
  end

  assign events = reset ? '0 : (din ^ hist);

endmodule

// File: rtl/la_bec_loader.sv
// Bridges firmware LA commands to the BEC core: operand assembly, launch, result capture and read-back.
module la_bec_loader
  import la_bec_pkg::*;
#(
  parameter int WIDTH  = 163,
  parameter int NWORDS = nwords(WIDTH)
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic [31:0]      la_wdata,
  input  logic [15:0]      la_ctrl,
  output logic [31:0]      la_rdata,
  output logic [15:0]      la_status,
  output logic [WIDTH-1:0] bec_key,
  output logic [WIDTH-1:0] bec_xp,
  output logic [WIDTH-1:0] bec_yp,
  output logic             bec_start,
  input  logic             bec_done,
  input  logic [WIDTH-1:0] bec_result,
  output logic             irq
);

  localparam int BUFW  = NWORDS * 32;
  localparam int MASKW = 3 * NWORDS;
  localparam int BW    = $clog2(BUFW);
  localparam int MW    = $clog2(MASKW);
  localparam logic [BUFW-1:0] VALID_MASK = {BUFW{1'b1}} >> (BUFW - WIDTH);

  logic [3:0]       tgl_q;
  logic [1:0]       sel_q;
  logic [2:0]       idx_q;
  logic [31:0]      wdata_q;
  logic             unused_ctrl;
  logic [3:0]       events;
  logic             clr_ev, wr_ev, go_ev, rd_ev;
  logic             addr_ok, do_write, do_start, do_capture;
  state_t           state_q, state_d;
  logic             err_q, err_d;
  logic [BUFW-1:0]  key_buf, xp_buf, yp_buf, rd_src;
  logic [WIDTH-1:0] result_q;
  logic [MASKW-1:0] mask_q;
  logic [31:0]      rdata_q, rd_word;
  logic [15:0]      status_q;
  logic             irq_q, start_q;
  int               idx_i, sel_i;
  logic [BW-1:0]    wbase;
  logic [MW-1:0]    mask_idx;

  assign unused_ctrl = ^{la_ctrl[15:11], la_ctrl[7:6]};

  // Register the LA inputs once so everything downstream sees a clean, synchronous copy.
  always_ff @(posedge wb_clk_i) begin
    tgl_q   <= la_ctrl[CTRL_CLR:CTRL_WR];
    sel_q   <= la_ctrl[CTRL_SEL_LO +: 2];
    idx_q   <= la_ctrl[CTRL_IDX_LO +: 3];
    wdata_q <= la_wdata;
  end

  la_toggle_detect #(.N(4)) u_tgl (
    .clk    (wb_clk_i),
    .reset  (wb_rst_i),
    .din    (tgl_q),
    .events (events)
  );

  assign clr_ev = events[CTRL_CLR];
  assign wr_ev  = events[CTRL_WR] & ~clr_ev;
  assign go_ev  = events[CTRL_GO] & ~clr_ev & ~events[CTRL_WR];
  assign rd_ev  = events[CTRL_RD] & ~clr_ev & ~events[CTRL_WR] & ~events[CTRL_GO];

  assign idx_i    = int'(idx_q);
  assign sel_i    = int'(sel_q);
  assign addr_ok  = (sel_q != 2'd3) && (idx_i < NWORDS);
  assign wbase    = BW'(idx_i * 32);
  assign mask_idx = MW'(sel_i * NWORDS + idx_i);

  // Next-state logic: resolves the single surviving command plus the core's completion pulse.
  always_comb begin
    state_d    = state_q;
    err_d      = err_q;
    do_write   = 1'b0;
    do_start   = 1'b0;
    do_capture = 1'b0;
    if (clr_ev) begin
      state_d = S_IDLE;
      err_d   = 1'b0;
    end else begin
      if (wr_ev && state_q != S_BUSY) begin
        if (addr_ok) begin
          do_write = 1'b1;
          state_d  = S_LOAD;
        end else begin
          err_d = 1'b1;
        end
      end
      if (go_ev) begin
        if (state_q == S_LOAD && (&mask_q)) begin
          do_start = 1'b1;
          state_d  = S_BUSY;
        end else begin
          err_d = 1'b1;
        end
      end
      if (state_q == S_BUSY && bec_done) begin
        do_capture = 1'b1;
        state_d    = S_DONE;
      end
    end
  end

  // State and sticky error register.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= S_IDLE;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  // Read-back mux: pick the register, hide bits above WIDTH, return zero for out-of-range words.
  always_comb begin
    rd_src = '0;
    case (sel_q)
      2'd0:    rd_src = key_buf;
      2'd1:    rd_src = xp_buf;
      2'd2:    rd_src = yp_buf;
      default: rd_src = BUFW'(result_q);
    endcase
    rd_src  = rd_src & VALID_MASK;
    rd_word = '0;
    if (idx_i < NWORDS) rd_word = rd_src[wbase +: 32];
  end

  // Datapath: operand buffers, loaded mask, result capture and the registered outputs.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      key_buf  <= '0;
      xp_buf   <= '0;
      yp_buf   <= '0;
      result_q <= '0;
      mask_q   <= '0;
      rdata_q  <= '0;
      status_q <= STATUS_IDLE;
      irq_q    <= 1'b0;
      start_q  <= 1'b0;
    end else begin
      status_q <= status_code(state_d, err_d);
      irq_q    <= (state_d == S_DONE);
      start_q  <= do_start;
      if (clr_ev) begin
        key_buf  <= '0;
        xp_buf   <= '0;
        yp_buf   <= '0;
        result_q <= '0;
        mask_q   <= '0;
      end else begin
        if (do_write) begin
          case (sel_q)
            2'd0:    key_buf[wbase +: 32] <= wdata_q;
            2'd1:    xp_buf[wbase +: 32]  <= wdata_q;
            default: yp_buf[wbase +: 32]  <= wdata_q;
          endcase
          mask_q[mask_idx] <= 1'b1;
        end
        if (do_capture) result_q <= bec_result;
      end
      if (rd_ev) rdata_q <= rd_word;
    end
  end

  assign bec_key   = key_buf[WIDTH-1:0];
  assign bec_xp    = xp_buf[WIDTH-1:0];
  assign bec_yp    = yp_buf[WIDTH-1:0];
  assign bec_start = start_q;
  assign la_rdata  = rdata_q;
  assign la_status = status_q;
  assign irq       = irq_q;

endmodule

// File: tb/tb_la_bec_loader.sv
// Directed self-checking bench for la_bec_loader.
module tb_la_bec_loader;

  localparam int WIDTH = 163;
  localparam logic [3:0] WR  = 4'b0001;
  localparam logic [3:0] GO  = 4'b0010;
  localparam logic [3:0] RD  = 4'b0100;
  localparam logic [3:0] CLR = 4'b1000;

  logic             clk = 1'b0;
  logic             rst;
  logic [31:0]      la_wdata;
  logic [15:0]      la_ctrl;
  logic [31:0]      la_rdata;
  logic [15:0]      la_status;
  logic [WIDTH-1:0] bec_key, bec_xp, bec_yp, bec_result;
  logic             bec_start, bec_done, irq;

  logic [3:0]       tgl;
  int               tests_run = 0;
  int               failed = 0;
  int               start_count = 0;

  la_bec_loader #(.WIDTH(WIDTH)) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .la_wdata   (la_wdata),
    .la_ctrl    (la_ctrl),
    .la_rdata   (la_rdata),
    .la_status  (la_status),
    .bec_key    (bec_key),
    .bec_xp     (bec_xp),
    .bec_yp     (bec_yp),
    .bec_start  (bec_start),
    .bec_done   (bec_done),
    .bec_result (bec_result),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  // Count launch pulses away from the active edge.
  always @(negedge clk) if (bec_start) start_count++;

  function automatic logic [31:0] vec(input int s, input int w);
    return 32'h1000_0000 * (s + 1) + w;
  endfunction

  // Toggle the requested command bits with the given fields, then allow enough edges for the action.
  task automatic send(input logic [3:0] bits, input int sel, input int idx, input logic [31:0] data);
    logic [1:0] s2;
    logic [2:0] i3;
    s2 = 2'(sel);
    i3 = 3'(idx);
    @(negedge clk);
    tgl      = tgl ^ bits;
    la_ctrl  = {5'b0, i3, 2'b0, s2, tgl};
    la_wdata = data;
    repeat (3) @(negedge clk);
  endtask

  task automatic load_all(input int skip);
    for (int s = 0; s < 3; s++)
      for (int w = 0; w < 6; w++)
        if (s * 6 + w != skip) send(WR, s, w, vec(s, w));
  endtask

  task automatic pulse_done(input logic [WIDTH-1:0] r);
    @(negedge clk);
    bec_result = r;
    bec_done   = 1'b1;
    @(negedge clk);
    bec_done   = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    tgl      = 4'h5;
    la_ctrl  = 16'h0035;
    la_wdata = 32'hDEAD_BEEF;
    bec_done = 1'b0;
    bec_result = '0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if (la_status !== 16'hAB30) begin failed++; $display("[TB] FAIL reset_status got %h want ab30", la_status); end
    tests_run++;
    if (irq !== 1'b0 || bec_start !== 1'b0 || la_rdata !== 32'h0) begin
      failed++; $display("[TB] FAIL reset_outputs got irq=%b start=%b rdata=%h want 0/0/0", irq, bec_start, la_rdata);
    end
    tests_run++;
    if (bec_key !== '0 || bec_xp !== '0 || bec_yp !== '0) begin failed++; $display("[TB] FAIL reset_operands got nonzero want 0"); end
    repeat (20) @(negedge clk);
    tests_run++;
    if (la_status !== 16'hAB30 || start_count != 0) begin
      failed++; $display("[TB] FAIL reset_no_event got status=%h starts=%0d want ab30/0", la_status, start_count);
    end
  endtask

  task automatic test_full_run();
    int sc;
    logic [191:0] full;
    logic [31:0]  exp;
    send(CLR, 0, 0, 0);
    load_all(-1);
    tests_run++;
    if (la_status !== 16'hAB41) begin failed++; $display("[TB] FAIL load_status got %h want ab41", la_status); end
    tests_run++;
    if (bec_key[31:0] !== 32'h1000_0000 || bec_xp[63:32] !== 32'h2000_0001 || bec_yp[162:160] !== 3'h5) begin
      failed++; $display("[TB] FAIL operand_bus got key0=%h xp1=%h yp_top=%h want 10000000/20000001/5", bec_key[31:0], bec_xp[63:32], bec_yp[162:160]);
    end
    sc = start_count;
    send(GO, 0, 0, 0);
    repeat (3) @(negedge clk);
    tests_run++;
    if (start_count - sc != 1 || la_status !== 16'hAB42) begin
      failed++; $display("[TB] FAIL go_start got pulses=%0d status=%h want 1/ab42", start_count - sc, la_status);
    end
    full = {6{32'h5A5A_A5A5}};
    pulse_done(full[WIDTH-1:0]);
    tests_run++;
    if (la_status !== 16'hAB51 || irq !== 1'b1) begin
      failed++; $display("[TB] FAIL done_status got %h irq=%b want ab51/1", la_status, irq);
    end
    for (int w = 0; w < 6; w++) begin
      send(RD, 3, w, 0);
      exp = (w == 5) ? 32'h0000_0005 : 32'h5A5A_A5A5;
      tests_run++;
      if (la_rdata !== exp) begin failed++; $display("[TB] FAIL read_result_%0d got %h want %h", w, la_rdata, exp); end
    end
    send(RD, 0, 5, 0);
    tests_run++;
    if (la_rdata !== 32'h0000_0005) begin failed++; $display("[TB] FAIL read_key5_masked got %h want 00000005", la_rdata); end
    send(WR, 0, 0, 32'h1000_0000);
    tests_run++;
    if (la_status !== 16'hAB41 || irq !== 1'b0) begin
      failed++; $display("[TB] FAIL write_from_done got %h irq=%b want ab41/0", la_status, irq);
    end
  endtask

  task automatic test_incomplete_go();
    int sc;
    send(CLR, 0, 0, 0);
    tests_run++;
    if (la_status !== 16'hAB30 || irq !== 1'b0) begin failed++; $display("[TB] FAIL clear_idle got %h irq=%b want ab30/0", la_status, irq); end
    load_all(17);
    sc = start_count;
    send(GO, 0, 0, 0);
    repeat (2) @(negedge clk);
    tests_run++;
    if (la_status !== 16'hAB44 || start_count != sc) begin
      failed++; $display("[TB] FAIL go_incomplete got %h pulses=%0d want ab44/0", la_status, start_count - sc);
    end
    send(WR, 2, 5, vec(2, 5));
    send(GO, 0, 0, 0);
    repeat (2) @(negedge clk);
    tests_run++;
    if (la_status !== 16'hAB44 || start_count - sc != 1) begin
      failed++; $display("[TB] FAIL go_after_fix got %h pulses=%0d want ab44/1", la_status, start_count - sc);
    end
    pulse_done({WIDTH{1'b1}});
    tests_run++;
    if (la_status !== 16'hAB44 || irq !== 1'b1) begin failed++; $display("[TB] FAIL err_sticky_done got %h irq=%b want ab44/1", la_status, irq); end
    send(CLR, 0, 0, 0);
    tests_run++;
    if (la_status !== 16'hAB30 || irq !== 1'b0) begin failed++; $display("[TB] FAIL clear_err got %h irq=%b want ab30/0", la_status, irq); end
  endtask

  task automatic test_illegal_write();
    int sc;
    send(WR, 0, 0, 32'hCAFE_0001);
    send(WR, 0, 6, 32'hBAD0_0006);
    tests_run++;
    if (la_status !== 16'hAB44) begin failed++; $display("[TB] FAIL write_idx6 got %h want ab44", la_status); end
    send(WR, 3, 0, 32'hBAD0_0003);
    tests_run++;
    if (bec_key !== {{(WIDTH-32){1'b0}}, 32'hCAFE_0001} || bec_xp !== '0 || bec_yp !== '0) begin
      failed++; $display("[TB] FAIL illegal_unchanged got key0=%h want cafe0001 and others 0", bec_key[31:0]);
    end
    send(RD, 0, 0, 0);
    send(RD, 0, 6, 0);
    tests_run++;
    if (la_rdata !== 32'h0) begin failed++; $display("[TB] FAIL read_idx6 got %h want 00000000", la_rdata); end
    send(CLR, 0, 0, 0);
    load_all(0);
    sc = start_count;
    send(GO, 0, 0, 0);
    repeat (2) @(negedge clk);
    tests_run++;
    if (start_count != sc || la_status !== 16'hAB44) begin
      failed++; $display("[TB] FAIL mask_unchanged got pulses=%0d status=%h want 0/ab44", start_count - sc, la_status);
    end
    send(CLR, 0, 0, 0);
  endtask

  task automatic test_clear_busy();
    load_all(-1);
    send(GO, 0, 0, 0);
    tests_run++;
    if (la_status !== 16'hAB42) begin failed++; $display("[TB] FAIL busy_status got %h want ab42", la_status); end
    send(CLR, 0, 0, 0);
    tests_run++;
    if (la_status !== 16'hAB30 || bec_key !== '0 || bec_xp !== '0 || bec_yp !== '0) begin
      failed++; $display("[TB] FAIL clear_busy got %h key0=%h want ab30 and zero operands", la_status, bec_key[31:0]);
    end
    pulse_done({WIDTH{1'b1}});
    send(RD, 3, 0, 0);
    tests_run++;
    if (la_status !== 16'hAB30 || irq !== 1'b0 || la_rdata !== 32'h0) begin
      failed++; $display("[TB] FAIL late_done got %h irq=%b res0=%h want ab30/0/0", la_status, irq, la_rdata);
    end
  endtask

  task automatic test_back_to_back();
    int sc;
    send(CLR, 0, 0, 0);
    load_all(17);
    sc = start_count;
    send(WR | GO, 2, 5, vec(2, 5));
    repeat (2) @(negedge clk);
    tests_run++;
    if (la_status !== 16'hAB41 || start_count != sc || bec_yp[162:160] !== 3'h5) begin
      failed++; $display("[TB] FAIL wr_go_same got %h pulses=%0d yp_top=%h want ab41/0/5", la_status, start_count - sc, bec_yp[162:160]);
    end
    send(GO, 0, 0, 0);
    repeat (2) @(negedge clk);
    tests_run++;
    if (la_status !== 16'hAB42 || start_count - sc != 1) begin
      failed++; $display("[TB] FAIL go_after_b2b got %h pulses=%0d want ab42/1", la_status, start_count - sc);
    end
  endtask

  initial begin
    test_reset();
    test_full_run();
    test_incomplete_go();
    test_illegal_write();
    test_clear_busy();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
